// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period of pwm_in in clk cycles.
// Optional glitch filter on the conditioned level: PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
  parameter int TIMEOUT    = 16'hFFFF,
  parameter int FILTER_LEN = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pwm_in,
  output logic [15:0] pulse_width,
  output logic [15:0] cycle_width,
  output logic        meas_valid,
  output logic        signal_lost,
  output logic        in_level
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    LOST
  } state_t;

  localparam logic [15:0] TO = 16'(TIMEOUT);

  state_t      state, state_n;
  logic        s1, s2;
  logic        lvl, lvl_d;
  logic        rise, fall;
  logic [15:0] cnt, cnt_n;
  logic [15:0] high_cnt, hc_n;
  logic [15:0] pw_n, cw_n;
  logic        mv_n, sl_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int RW = $clog2(FILTER_LEN + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(FILTER_LEN - 1);

  logic          lvl_q;
  logic [RW-1:0] run;
  logic          accept;

  // The current sample counts as the last of the FILTER_LEN run.
  assign accept = (s2 != lvl_q) && (run == RUN_MAX);
  assign lvl    = accept ? s2 : lvl_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lvl_q <= 1'b0;
      run   <= '0;
    end else if (s2 == lvl_q) begin
      run <= '0;
    end else if (accept) begin
      lvl_q <= s2;
      run   <= '0;
    end else begin
      run <= run + 1'b1;
    end
  end
`else
  localparam int unused_filter_len = FILTER_LEN;

  assign lvl = s2;
`endif

  assign rise     = lvl & ~lvl_d;
  assign fall     = ~lvl & lvl_d;
  assign in_level = lvl;

  always_comb begin
    state_n = state;
    hc_n    = high_cnt;
    pw_n    = pulse_width;
    cw_n    = cycle_width;
    mv_n    = 1'b0;
    sl_n    = signal_lost;
    if (rise)
      cnt_n = 16'd1;
    else if (cnt < TO)
      cnt_n = cnt + 16'd1;
    else
      cnt_n = cnt;
    unique case (state)
      IDLE: begin
        if (rise)
          state_n = HIGH;
      end
      HIGH: begin
        if (cnt == TO) begin
          sl_n    = 1'b1;
          state_n = LOST;
        end else if (fall) begin
          hc_n    = cnt;
          state_n = LOW;
        end
      end
      LOW: begin
        // A rise on the timeout cycle still completes the period.
        if (rise) begin
          cw_n    = cnt;
          pw_n    = high_cnt;
          mv_n    = 1'b1;
          state_n = HIGH;
        end else if (cnt == TO) begin
          sl_n    = 1'b1;
          state_n = LOST;
        end
      end
      LOST: begin
        if (rise) begin
          sl_n    = 1'b0;
          state_n = HIGH;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      lvl_d       <= 1'b0;
      cnt         <= '0;
      high_cnt    <= '0;
      pulse_width <= '0;
      cycle_width <= '0;
      meas_valid  <= 1'b0;
      signal_lost <= 1'b0;
    end else begin
      state       <= state_n;
      lvl_d       <= lvl;
      cnt         <= cnt_n;
      high_cnt    <= hc_n;
      pulse_width <= pw_n;
      cycle_width <= cw_n;
      meas_valid  <= mv_n;
      signal_lost <= sl_n;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: directed PWM periods, expected
// measurements queued at each rise and checked on every strobe.
module tb_pwm_capture;

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FD = 2;
`else
  localparam int FD = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pwm_in;
  logic [15:0] pulse_width;
  logic [15:0] cycle_width;
  logic        meas_valid;
  logic        signal_lost;
  logic        in_level;

  typedef struct packed {
    logic [15:0] pw;
    logic [15:0] cw;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  logic prev_valid = 1'b0;
  int   prev_p = 0;
  int   prev_c = 0;
  logic mv_last = 1'b0;

  pwm_capture #(
    .TIMEOUT(100),
    .FILTER_LEN(3)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .pwm_in(pwm_in),
    .pulse_width(pulse_width),
    .cycle_width(cycle_width),
    .meas_valid(meas_valid),
    .signal_lost(signal_lost),
    .in_level(in_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_prev();
    if (prev_valid)
      q.push_back({16'(prev_p), 16'(prev_c)});
  endtask

  task automatic period(input int p, input int c);
    push_prev();
    pwm_in = 1'b1;
    cyc(p);
    pwm_in = 1'b0;
    cyc(c - p);
    prev_valid = 1'b1;
    prev_p = p;
    prev_c = c;
  endtask

  // 5-high period with a 1-cycle glitch 25 cycles after the rise.
  task automatic glitch_period();
    push_prev();
    pwm_in = 1'b1;
    cyc(5);
    pwm_in = 1'b0;
    cyc(20);
`ifndef PWM_CAPTURE_FILTER_EN
    q.push_back({16'd5, 16'd25});
`endif
    pwm_in = 1'b1;
    cyc(1);
    pwm_in = 1'b0;
    cyc(24);
    prev_valid = 1'b1;
`ifdef PWM_CAPTURE_FILTER_EN
    prev_p = 5;
    prev_c = 50;
`else
    prev_p = 1;
    prev_c = 25;
`endif
  endtask

  // Monitor: every strobe pops one expected measurement.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (meas_valid) begin
        checks++;
        if (mv_last) begin
          failures++;
          $display("FAIL strobe_width: meas_valid high 2 cycles");
        end
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe: got %0d/%0d expected none",
                   pulse_width, cycle_width);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("pulse_width", pulse_width, e.pw);
          chk("cycle_width", cycle_width, e.cw);
        end
      end
      mv_last <= meas_valid;
    end else begin
      mv_last <= 1'b0;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    cyc(3);
    chk("rst_pw", pulse_width, 0);
    chk("rst_cw", cycle_width, 0);
    chk("rst_mv", meas_valid, 0);
    chk("rst_sl", signal_lost, 0);
    chk("rst_lvl", in_level, 0);
    rst_n = 1'b1;
    cyc(2);

    repeat (5) period(3, 10);
    chk("stream_sl", signal_lost, 0);
    repeat (2) period(7, 20);
    repeat (2) period(3, 10);

    // Hold high: loss declared exactly TIMEOUT cycles after the load.
    push_prev();
    pwm_in = 1'b1;
    cyc(102 + FD);
    chk("hold_sl_before", signal_lost, 0);
    cyc(1);
    chk("hold_sl", signal_lost, 1);
    chk("hold_lvl", in_level, 1);
    chk("hold_pw", pulse_width, 3);
    chk("hold_cw", cycle_width, 10);
    prev_valid = 1'b0;
    pwm_in = 1'b0;
    cyc(5);
    chk("lost_low_sl", signal_lost, 1);
    period(3, 10);
    chk("resume_sl", signal_lost, 0);
    period(3, 10);

    // Period exactly TIMEOUT is valid; TIMEOUT+1 is lost.
    period(40, 100);
    period(40, 100);
    period(3, 10);
    chk("p100_sl", signal_lost, 0);
    period(40, 101);
    cyc(3 + FD);
    chk("p101_sl", signal_lost, 1);
    chk("p101_lvl", in_level, 0);
    prev_valid = 1'b0;
    period(3, 10);
    period(3, 10);

    // Asynchronous reset in the middle of a high pulse.
    push_prev();
    pwm_in = 1'b1;
    cyc(6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pw", pulse_width, 0);
    chk("arst_cw", cycle_width, 0);
    chk("arst_mv", meas_valid, 0);
    chk("arst_sl", signal_lost, 0);
    chk("arst_lvl", in_level, 0);
    @(negedge clk);
    pwm_in = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    prev_valid = 1'b0;
    cyc(2);
    repeat (3) period(3, 10);

    // Glitch on the low phase between 5/50 periods.
    period(5, 50);
    glitch_period();
    period(5, 50);
    period(5, 50);
    push_prev();
    pwm_in = 1'b1;
    cyc(10);
    pwm_in = 1'b0;
    cyc(20);

    chk("queue_drained", 16'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the PWM generator channel: measures the high time and period of an incoming PWM waveform, in clk cycles.
- Sits behind a board input pin.
- Publishes the latest complete measurement with a one-cycle valid strobe, plus a loss-of-signal flag for stuck-high or stuck-low inputs.
- A waveform driven with pulse width P and cycle width C, in the same clock domain, reads back exactly P and C.

Parameters:
- TIMEOUT, 16'hFFFF, max cycles counted since the last rising edge before declaring signal lost; legal range 2..65535.
- FILTER_LEN, 3, consecutive equal samples required to accept a level change; used only with PWM_CAPTURE_FILTER_EN.

Ports:
- clk  input  1  system clock; all state on posedge.
- reset  input  1  asynchronous, active-low reset.
- pwm_in  input  1  PWM waveform, asynchronous to clk.
- pulse_width  output  16  high cycles of the last complete period.
- cycle_width  output  16  total cycles of the last complete period.
- meas_valid  output  1  one-cycle strobe: pulse_width/cycle_width just updated.
- signal_lost  output  1  no rising edge within TIMEOUT cycles.
- in_level  output  1  conditioned (synchronised, optionally filtered) input level.

Behaviour:
- Reset (reset=0, async):
  - pulse_width=0, cycle_width=0, meas_valid=0, signal_lost=0, in_level=0.
  - Synchroniser flops=0, cnt=0, high_cnt=0, state=IDLE.
  - Takes effect immediately, including mid-period; the partial period is discarded.
- Conditioning:
  - pwm_in passes through a 2-flop synchroniser, giving s.
  - lvl = s, or the filtered s when the optional feature is enabled.
  - rise = lvl & ~lvl_d; fall = ~lvl & lvl_d. lvl_d is lvl delayed one cycle.
  - in_level = lvl.
- Counter cnt (16 bit):
  - Loads 1 on a rise cycle.
  - Otherwise increments each cycle while cnt < TIMEOUT.
  - Saturates at TIMEOUT; never wraps.
- FSM states IDLE, HIGH, LOW, LOST:
  - IDLE: ignore fall. On rise: cnt<=1, go HIGH, no meas_valid, because the first period after reset is incomplete.
  - HIGH: on fall: high_cnt<=cnt, go LOW.
  - LOW, on rise:
    - cycle_width<=cnt, pulse_width<=high_cnt, meas_valid<=1, cnt<=1, go HIGH.
  - HIGH or LOW, cnt==TIMEOUT and no rise in the same cycle:
    - signal_lost<=1, go LOST. Outputs hold their last measurement.
  - LOST: on rise: signal_lost<=0, cnt<=1, go HIGH, no meas_valid. The next rise produces a valid measurement.
- Boundary conditions:
  - rise in the same cycle cnt==TIMEOUT: the measurement wins, and a period of exactly TIMEOUT is valid.
  - A rise seen in HIGH with no intervening fall cannot occur. Edges alternate because lvl is one bit.
  - 100% duty (rise never recurs) is reported as signal_lost with in_level=1.
  - 0% duty is reported as signal_lost with in_level=0.
- Latency: meas_valid rises on the 3rd clk edge after the first edge that samples pwm_in high.
  - Add FILTER_LEN-1 edges when the filter is enabled.
  - It is exactly one cycle wide.

Optional Feature:
- PWM_CAPTURE_FILTER_EN defined:
  - lvl changes only after FILTER_LEN consecutive identical s samples.
  - Uses a small run counter, reset to 0 with lvl=0.
  - Both edges are delayed equally, so measured widths are unchanged for pulses and gaps of at least FILTER_LEN.
  - Shorter glitches are suppressed entirely.
- Undefined: lvl = s directly, and a single-cycle pulse is measured as pulse_width=1.

Test Plan:
- Synchronous P=3, C=10 repeating for 5 periods -> no strobe on the first rise; then meas_valid once per 10 cycles with pulse_width=3, cycle_width=10; signal_lost stays 0.
- Switch stimulus from P=3/C=10 to P=7/C=20 at a period boundary -> the next strobe reports 3/10, the one after reports 7/20, and there are no intermediate values.
- TIMEOUT=100, valid 3/10 stream, then hold pwm_in high -> signal_lost=1 exactly 100 cycles after the last counter load; in_level=1; outputs hold 3/10. Resume 3/10 -> signal_lost clears on the first rise with no strobe; the second rise strobes 3/10.
- TIMEOUT=100, period exactly 100 (P=40) -> meas_valid with 40/100, signal_lost never set. Period 101 -> signal_lost set and no strobe.
- Assert reset mid-high-pulse of a 3/10 stream -> all outputs 0 with no clk edge needed. After release, the first rise gives no strobe and the second strobes 3/10.
- 1-cycle high glitch on a low line between 5/50 periods -> without PWM_CAPTURE_FILTER_EN it produces a strobe with pulse_width=1. With the feature and FILTER_LEN=3 it is ignored and the next strobe is 5/50.
